// File: rtl/iter_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with a tagged valid/ready
// request and response, flush abort, and single-edge divide-by-zero/overflow paths.
module iter_divider #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned TAG_W          = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             flush_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_value_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o
);

    localparam int unsigned N_ITER = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = $clog2(N_ITER);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               sel_rem_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic [TAG_W-1:0]   tag_q;

    logic               req_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               div_zero;
    logic               sgn_ovf;
    logic [WIDTH-1:0]   special_val;

    logic [WIDTH:0]     rem_n;
    logic [WIDTH-1:0]   quo_n;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   q_fin;
    logic [WIDTH-1:0]   r_fin;
    logic [WIDTH-1:0]   result;

    assign req_ready_o = (state_q == IDLE) && !flush_i;
    assign busy_o      = (state_q != IDLE);

    // Request decode: magnitudes, sign flags and the single-edge special results
    always_comb begin
        req_signed  = ~req_op_i[0];
        a_neg       = req_signed & req_a_i[WIDTH-1];
        b_neg       = req_signed & req_b_i[WIDTH-1];
        a_mag       = a_neg ? -req_a_i : req_a_i;
        b_mag       = b_neg ? -req_b_i : req_b_i;
        div_zero    = (req_b_i == '0);
        sgn_ovf     = req_signed && (req_a_i == MIN_VAL) && (req_b_i == '1);
        special_val = '0;
        if (div_zero) begin
            special_val = req_op_i[1] ? req_a_i : '1;
        end else begin
            special_val = req_op_i[1] ? '0 : req_a_i;
        end
    end

    // BITS_PER_CYCLE restoring steps; dividend bits shift out of quo as quotient bits shift in
    always_comb begin
        rem_n = rem_q;
        quo_n = quo_q;
        trial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            trial = {rem_n[WIDTH-1:0], quo_n[WIDTH-1]};
            quo_n = {quo_n[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                rem_n    = trial - {1'b0, dvs_q};
                quo_n[0] = 1'b1;
            end else begin
                rem_n = trial;
            end
        end
        q_fin  = neg_q_q ? -quo_n : quo_n;
        r_fin  = neg_r_q ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
        result = sel_rem_q ? r_fin : q_fin;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sel_rem_q   <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            tag_q       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_value_o <= '0;
            rsp_tag_o   <= '0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_value_o <= '0;
            rsp_tag_o   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        sel_rem_q <= req_op_i[1];
                        tag_q     <= req_tag_i;
                        if (div_zero || sgn_ovf) begin
                            state_q     <= DONE;
                            rsp_valid_o <= 1'b1;
                            rsp_value_o <= special_val;
                            rsp_tag_o   <= req_tag_i;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= '0;
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            neg_q_q <= a_neg ^ b_neg;
                            neg_r_q <= a_neg;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_ITER - 1)) begin
                        state_q     <= DONE;
                        cnt_q       <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_value_o <= result;
                        rsp_tag_o   <= tag_q;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_value_o <= '0;
                        rsp_tag_o   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: three configurations checked against an arithmetic
// reference (integer / and %) with directed corner cases and random operands.
module tb_iter_divider;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // dut0: W32/B1, dut1: W32/B4, dut2: W16/B2
    logic        v0, v1, v2, f0, f1, f2, rr0, rr1, rr2;
    logic [1:0]  op0, op1, op2;
    logic [31:0] a0, b0, a1, b1;
    logic [15:0] a2, b2;
    logic [4:0]  t0, t1, t2;
    logic        rdy0, rdy1, rdy2, rv0, rv1, rv2, bz0, bz1, bz2;
    logic [31:0] val0, val1;
    logic [15:0] val2;
    logic [4:0]  tg0, tg1, tg2;

    iter_divider #(.WIDTH(32), .BITS_PER_CYCLE(1), .TAG_W(5)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .req_valid_i(v0), .req_ready_o(rdy0),
        .req_op_i(op0), .req_a_i(a0), .req_b_i(b0), .req_tag_i(t0), .flush_i(f0),
        .rsp_valid_o(rv0), .rsp_ready_i(rr0), .rsp_value_o(val0), .rsp_tag_o(tg0),
        .busy_o(bz0));

    iter_divider #(.WIDTH(32), .BITS_PER_CYCLE(4), .TAG_W(5)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_valid_i(v1), .req_ready_o(rdy1),
        .req_op_i(op1), .req_a_i(a1), .req_b_i(b1), .req_tag_i(t1), .flush_i(f1),
        .rsp_valid_o(rv1), .rsp_ready_i(rr1), .rsp_value_o(val1), .rsp_tag_o(tg1),
        .busy_o(bz1));

    iter_divider #(.WIDTH(16), .BITS_PER_CYCLE(2), .TAG_W(5)) u_dut2 (
        .clk_i(clk), .rst_i(rst_n), .req_valid_i(v2), .req_ready_o(rdy2),
        .req_op_i(op2), .req_a_i(a2), .req_b_i(b2), .req_tag_i(t2), .flush_i(f2),
        .rsp_valid_o(rv2), .rsp_ready_i(rr2), .rsp_value_o(val2), .rsp_tag_o(tg2),
        .busy_o(bz2));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    function automatic int dut_w(input int d);
        return (d == 2) ? 16 : 32;
    endfunction

    function automatic int dut_n(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] dut_mask(input int d);
        return (d == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    task automatic set_in(input int d, input logic v, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        case (d)
            0: begin v0 = v; op0 = op; a0 = a; b0 = b; t0 = t; end
            1: begin v1 = v; op1 = op; a1 = a; b1 = b; t1 = t; end
            default: begin v2 = v; op2 = op; a2 = a[15:0]; b2 = b[15:0]; t2 = t; end
        endcase
    endtask

    task automatic set_rr(input int d, input logic r);
        case (d)
            0: rr0 = r;
            1: rr1 = r;
            default: rr2 = r;
        endcase
    endtask

    task automatic set_fl(input int d, input logic f);
        case (d)
            0: f0 = f;
            1: f1 = f;
            default: f2 = f;
        endcase
    endtask

    function automatic logic o_rv(input int d);
        return (d == 0) ? rv0 : (d == 1) ? rv1 : rv2;
    endfunction
    function automatic logic o_rdy(input int d);
        return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
    endfunction
    function automatic logic o_busy(input int d);
        return (d == 0) ? bz0 : (d == 1) ? bz1 : bz2;
    endfunction
    function automatic logic [4:0] o_tag(input int d);
        return (d == 0) ? tg0 : (d == 1) ? tg1 : tg2;
    endfunction
    function automatic logic [31:0] o_val(input int d);
        return (d == 0) ? val0 : (d == 1) ? val1 : {16'h0, val2};
    endfunction

    // Reference: plain integer division with the divide-by-zero convention
    function automatic logic [31:0] ref_div(input int w, input logic [1:0] op,
                                            input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        longint sa, sb, q, r;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a = a_in & mask;
        b = b_in & mask;
        if (b == 0) return op[1] ? a : mask;
        if (!op[0]) begin
            sa = (w == 32) ? longint'($signed(a)) : longint'($signed(a[15:0]));
            sb = (w == 32) ? longint'($signed(b)) : longint'($signed(b[15:0]));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return (op[1] ? 32'(r) : 32'(q)) & mask;
    endfunction

    function automatic bit is_special(input int w, input logic [1:0] op,
                                      input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask;
        logic [31:0] mn;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        mn   = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
        if ((b & mask) == 0) return 1'b1;
        return !op[0] && ((a & mask) == mn) && ((b & mask) == mask);
    endfunction

    // One transaction: accept, latency, value/tag, hold under back-pressure, handshake
    task automatic run_op(input int d, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input int hold,
                          input bit poke);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        exp     = ref_div(dut_w(d), op, a, b);
        exp_lat = is_special(dut_w(d), op, a, b) ? 0 : dut_n(d);
        @(negedge clk);
        set_in(d, 1'b1, op, a, b, tag);
        chk("req_ready", 64'(o_rdy(d)), 64'd1);
        @(posedge clk);
        #1;
        set_in(d, 1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        lat = 0;
        while (!o_rv(d) && lat < dut_n(d) + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("value", 64'(o_val(d)), 64'(exp));
        chk("tag", 64'(o_tag(d)), 64'(tag));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold", {24'h0, o_rv(d), o_rdy(d), o_busy(d), o_tag(d), o_val(d)},
                {24'h0, 1'b1, 1'b0, 1'b1, tag, exp});
        end
        @(negedge clk);
        set_rr(d, 1'b1);
        if (poke) set_in(d, 1'b1, op, a, b, tag);
        @(posedge clk);
        #1;
        set_rr(d, 1'b0);
        set_in(d, 1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        chk("release", {26'h0, o_rv(d), o_busy(d), o_tag(d), o_val(d)}, 64'h0);
    endtask

    task automatic watch(input int d, input int cyc);
        int seen;
        seen = 0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk);
            #1;
            if (o_rv(d) || o_busy(d)) seen++;
        end
        chk("quiet", 64'(seen), 64'd0);
    endtask

    task automatic rand_ops(input int d, input int cnt);
        logic [31:0] a, b, mask, mn;
        logic [1:0]  op;
        mask = dut_mask(d);
        mn   = (dut_w(d) == 32) ? 32'h8000_0000 : 32'h0000_8000;
        for (int k = 0; k < cnt; k++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       a = mn;
                1:       a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:          b = 32'h0;
                1:          b = mask;
                2, 3, 4:    b = $urandom_range(1, 15);
                default:    b = $urandom;
            endcase
            run_op(d, op, a & mask, b & mask, 5'($urandom), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            set_in(d, 1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
            set_rr(d, 1'b0);
            set_fl(d, 1'b0);
        end
        #2;
        chk("reset_state", {26'h0, o_rv(0), o_busy(0), o_tag(0), o_val(0)}, 64'h0);
        chk("reset_ready", 64'(o_rdy(0)), 64'd1);
        #5;
        rst_n = 1'b1;

        // first request is accepted on the first edge after reset release
        run_op(0, OP_DIV,  32'd20,        32'd5,         5'd7, 0, 1'b0);
        run_op(0, OP_REM,  32'd20,        32'd5,         5'd7, 0, 1'b0);
        run_op(0, OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd1, 0, 1'b0);
        run_op(0, OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd2, 1, 1'b0);
        run_op(0, OP_DIVU, 32'hFFFF_FFF9, 32'd2,         5'd3, 0, 1'b1);
        run_op(0, OP_DIVU, 32'h0000_1234, 32'd0,         5'd4, 0, 1'b0);
        run_op(0, OP_REM,  32'h0000_1234, 32'd0,         5'd5, 0, 1'b0);
        run_op(0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, 1'b0);
        run_op(0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 1'b0);
        run_op(0, OP_DIV,  32'd20,        32'd5,         5'd9, 5, 1'b1);
        run_op(1, OP_DIVU, 32'hFFFF_FFFF, 32'h10,        5'd3, 0, 1'b0);
        run_op(2, OP_DIV,  32'h8000,      32'hFFFF,      5'd4, 0, 1'b0);
        run_op(2, OP_REMU, 32'hFFFF,      32'h7,         5'd5, 0, 1'b0);

        // flush at the tenth CALC iteration
        @(negedge clk);
        set_in(0, 1'b1, OP_DIVU, 32'd1000, 32'd3, 5'd9);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        set_fl(0, 1'b1);
        @(posedge clk);
        #1;
        chk("flush_idle", {26'h0, o_rv(0), o_busy(0), o_tag(0), o_val(0)}, 64'h0);
        chk("flush_blocks_ready", 64'(o_rdy(0)), 64'd0);
        @(negedge clk);
        set_fl(0, 1'b0);
        #1;
        chk("ready_after_flush", 64'(o_rdy(0)), 64'd1);
        watch(0, 40);
        run_op(0, OP_DIVU, 32'd100, 32'd7, 5'd11, 0, 1'b0);

        // flush in DONE wins over the response handshake
        @(negedge clk);
        set_in(2, 1'b1, OP_DIVU, 32'd5, 32'd0, 5'd1);
        @(posedge clk);
        #1;
        set_in(2, 1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        chk("done_before_flush", 64'(o_rv(2)), 64'd1);
        @(negedge clk);
        set_fl(2, 1'b1);
        set_rr(2, 1'b1);
        @(posedge clk);
        #1;
        set_fl(2, 1'b0);
        set_rr(2, 1'b0);
        chk("flush_in_done", {26'h0, o_rv(2), o_busy(2), o_tag(2), o_val(2)}, 64'h0);

        // reset mid-CALC (dut0) and in DONE (dut1)
        @(negedge clk);
        set_in(0, 1'b1, OP_DIVU, 32'd500, 32'd9, 5'd2);
        set_in(1, 1'b1, OP_DIV,  32'd5,   32'd0, 5'd3);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        set_in(1, 1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("dut1_done_pre_reset", 64'(o_rv(1)), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_calc", {25'h0, o_rv(0), o_busy(0), o_rdy(0), o_tag(0), o_val(0)},
            {25'h0, 1'b0, 1'b0, 1'b1, 5'h0, 32'h0});
        chk("reset_done", {26'h0, o_rv(1), o_busy(1), o_tag(1), o_val(1)}, 64'h0);
        #1;
        rst_n = 1'b1;
        watch(0, 40);
        watch(1, 2);
        run_op(0, OP_DIVU, 32'd100, 32'd7, 5'd12, 0, 1'b0);

        rand_ops(0, 120);
        rand_ops(1, 60);
        rand_ops(2, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
